// File: rtl/des_decryption_iterative.sv
// Iterative DES decryptor: IP -> 16 Feistel rounds (subkeys K16..K1) -> FP.
// ROUNDS_PER_CYCLE rounds (1, 2 or 4) are chained combinationally each clock.
// Optional feature macro DES_DEC_CBC_EN: CBC-mode decryption with an IV/chain register.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holds valid (and its data) steady until that edge.
module des_decryption_iterative #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_ciphertext,
    input  logic [63:0] i_key,
    output logic        o_valid,
    input  logic        i_ready,
`ifdef DES_DEC_CBC_EN
    input  logic        i_iv_load,
    input  logic [63:0] i_iv,
`endif
    output logic [63:0] o_plaintext
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_param
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    // DES tables use bit 1 = MSB; a table entry n selects vector bit (W - n).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    // Cumulative left-rotation of C/D for subkey K(n+1); 28 is a full turn.
    localparam int SHIFT_T [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};
    // S-boxes, row-major: entry index = row*16 + col.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] initial_permutation(input logic [63:0] d);
        logic [63:0] q;
        for (int i = 0; i < 64; i++) q[63-i] = d[64-IP_T[i]];
        return q;
    endfunction

    function automatic logic [63:0] final_permutation(input logic [63:0] d);
        logic [63:0] q;
        for (int i = 0; i < 64; i++) q[63-i] = d[64-FP_T[i]];
        return q;
    endfunction

    function automatic void splitter(input logic [63:0] d, output logic [31:0] l, output logic [31:0] r);
        l = d[63:32];
        r = d[31:0];
    endfunction

    function automatic logic [63:0] concatenator(input logic [31:0] hi, input logic [31:0] lo);
        return {hi, lo};
    endfunction

    // PC1 drops the parity bits; the 56-bit C/D pair is what gets stored.
    function automatic logic [55:0] key_pc1(input logic [63:0] key);
        logic [55:0] q;
        for (int i = 0; i < 56; i++) q[55-i] = key[64-PC1_T[i]];
        return q;
    endfunction

    // Subkey for round index rnd (0 -> K1 .. 15 -> K16), computed directly from C0/D0.
    function automatic logic [47:0] key_generator(input logic [55:0] cd, input logic [3:0] rnd);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] rot;
        logic [47:0] k;
        int          s;
        s   = SHIFT_T[rnd];
        c   = (cd[55:28] << s) | (cd[55:28] >> (28 - s));
        d   = (cd[27:0]  << s) | (cd[27:0]  >> (28 - s));
        rot = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = rot[56-PC2_T[i]];
        return k;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    // One Feistel round; returns {L', R'}.
    function automatic logic [63:0] des_round(input logic [31:0] l, input logic [31:0] r, input logic [47:0] k);
        return {r, l ^ feistel(r, k)};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [4:0]  cnt;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [55:0] key_reg;
    logic [31:0] load_l;
    logic [31:0] load_r;
    logic [31:0] chain_l;
    logic [31:0] chain_r;
    logic [63:0] chain_mask;
    logic        accept;
    logic        last_step;
    logic        unused_parity;

    assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                             i_key[24], i_key[16], i_key[8], i_key[0]};
    assign accept    = i_valid & o_ready;
    assign last_step = (state == RUN) && (cnt + 5'(ROUNDS_PER_CYCLE) == 5'd16);

`ifdef DES_DEC_CBC_EN
    logic [63:0] chain_reg;
    logic [63:0] ct_reg;
    assign chain_mask = chain_reg;

    // CBC chain: IV load in IDLE, then each delivered block's ciphertext.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chain_reg <= '0;
            ct_reg    <= '0;
        end else begin
            if (state == IDLE && i_iv_load) chain_reg <= i_iv;
            if (accept) ct_reg <= i_ciphertext;
            if (state == DONE && i_ready) chain_reg <= ct_reg;
        end
    end
`else
    assign chain_mask = '0;
`endif

    // Split the permuted ciphertext into the initial L/R halves.
    always_comb begin
        load_l = '0;
        load_r = '0;
        splitter(initial_permutation(i_ciphertext), load_l, load_r);
    end

    // Chain ROUNDS_PER_CYCLE rounds; round j uses subkey index 15 - j.
    always_comb begin : round_chain
        logic [3:0] rnd;
        rnd     = '0;
        chain_l = l_reg;
        chain_r = r_reg;
        for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            rnd = cnt[3:0] + 4'(k);
            {chain_l, chain_r} = des_round(chain_l, chain_r, key_generator(key_reg, 4'd15 - rnd));
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next state and ready output; ready is forced low while reset is asserted.
    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = ~i_rst;
                if (i_valid && !i_rst) next_state = RUN;
            end
            RUN:     if (last_step) next_state = DONE;
            DONE:    if (i_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in RUN, hold result in DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt         <= '0;
            l_reg       <= '0;
            r_reg       <= '0;
            key_reg     <= '0;
            o_valid     <= 1'b0;
            o_plaintext <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_reg <= key_pc1(i_key);
                        l_reg   <= load_l;
                        r_reg   <= load_r;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    l_reg <= chain_l;
                    r_reg <= chain_r;
                    if (last_step) begin
                        cnt         <= '0;
                        o_plaintext <= final_permutation(concatenator(chain_r, chain_l)) ^ chain_mask;
                        o_valid     <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'(ROUNDS_PER_CYCLE);
                    end
                end
                DONE: begin
                    if (i_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
